// File: rtl/gb_cpu_sequencer.sv
// M-cycle sequencer: T-cycle phase, instruction register, CB-prefix flag and
// schedule slot index, with early termination, interrupt dispatch, HALT and lock.
module gb_cpu_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] opcode_fetched,
    input  logic [2:0] instr_len,
    input  logic [2:0] cond_len,
    input  logic       cond_true,
    input  logic       prefix_op,
    input  logic       halt_op,
    input  logic       illegal_op,
    input  logic       ime,
    input  logic       int_req,
    output logic [7:0] ir,
    output logic       cb_prefix,
    output logic [1:0] t_phase,
    output logic [2:0] m_idx,
    output logic       ir_load,
    output logic       instr_done,
    output logic       int_dispatch,
    output logic       halted,
    output logic       locked
);

    typedef enum logic [1:0] {
        S_EXEC,
        S_INT_DISPATCH,
        S_HALTED,
        S_LOCKED
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] t_phase_q, t_phase_d;
    logic [2:0] m_idx_q, m_idx_d;
    logic [7:0] ir_q, ir_d;
    logic       cb_q, cb_d;

    logic       boundary;
    logic [2:0] last_idx;
    logic       instr_end;

    assign boundary  = (t_phase_q == 2'd3);
    // A length of 0 behaves as a single M-cycle instruction.
    assign last_idx  = (instr_len == 3'd0) ? 3'd0 : instr_len - 3'd1;
    assign instr_end = (m_idx_q == last_idx) ||
                       ((cond_len != 3'd0) && (m_idx_q == cond_len - 3'd1) && !cond_true);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_EXEC;
            t_phase_q <= 2'd0;
            m_idx_q   <= 3'd0;
            ir_q      <= 8'h00;
            cb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_phase_q <= t_phase_d;
            m_idx_q   <= m_idx_d;
            ir_q      <= ir_d;
            cb_q      <= cb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        t_phase_d  = t_phase_q + 2'd1;
        m_idx_d    = m_idx_q;
        ir_d       = ir_q;
        cb_d       = cb_q;
        ir_load    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (boundary) begin
                    if (!instr_end) begin
                        m_idx_d = m_idx_q + 3'd1;
                    end else if (illegal_op) begin
                        state_d = S_LOCKED;
                    end else if (halt_op) begin
                        state_d    = S_HALTED;
                        m_idx_d    = 3'd0;
                        instr_done = 1'b1;
                    end else if (int_req && ime && !prefix_op) begin
                        // The overlapped fetch is discarded; ir keeps the finished opcode.
                        state_d    = S_INT_DISPATCH;
                        m_idx_d    = 3'd0;
                        instr_done = 1'b1;
                    end else begin
                        ir_d       = opcode_fetched;
                        cb_d       = prefix_op;
                        m_idx_d    = 3'd0;
                        ir_load    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
            end
            S_INT_DISPATCH: begin
                if (boundary) begin
                    if (m_idx_q == 3'd4) begin
                        state_d = S_EXEC;
                        m_idx_d = 3'd0;
                        ir_d    = opcode_fetched;
                        cb_d    = 1'b0;
                        ir_load = 1'b1;
                    end else begin
                        m_idx_d = m_idx_q + 3'd1;
                    end
                end
            end
            S_HALTED: begin
                m_idx_d = 3'd0;
                if (boundary && int_req) begin
                    if (ime) begin
                        state_d = S_INT_DISPATCH;
                    end else begin
                        state_d = S_EXEC;
                        ir_d    = opcode_fetched;
                        cb_d    = 1'b0;
                        ir_load = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                t_phase_d = t_phase_q;
            end
            default: begin
                state_d = S_EXEC;
            end
        endcase
    end

    assign ir           = ir_q;
    assign cb_prefix    = cb_q;
    assign t_phase      = t_phase_q;
    assign m_idx        = m_idx_q;
    assign int_dispatch = (state_q == S_INT_DISPATCH);
    assign halted       = (state_q == S_HALTED);
    assign locked       = (state_q == S_LOCKED);

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Directed bench for gb_cpu_sequencer: table of instruction lengths plus
// hand sequences for prefix, interrupt dispatch, HALT, lock and reset.
module tb_gb_cpu_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] opcode_fetched;
    logic [2:0] instr_len;
    logic [2:0] cond_len;
    logic       cond_true;
    logic       prefix_op;
    logic       halt_op;
    logic       illegal_op;
    logic       ime;
    logic       int_req;
    logic [7:0] ir;
    logic       cb_prefix;
    logic [1:0] t_phase;
    logic [2:0] m_idx;
    logic       ir_load;
    logic       instr_done;
    logic       int_dispatch;
    logic       halted;
    logic       locked;

    gb_cpu_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .opcode_fetched (opcode_fetched),
        .instr_len      (instr_len),
        .cond_len       (cond_len),
        .cond_true      (cond_true),
        .prefix_op      (prefix_op),
        .halt_op        (halt_op),
        .illegal_op     (illegal_op),
        .ime            (ime),
        .int_req        (int_req),
        .ir             (ir),
        .cb_prefix      (cb_prefix),
        .t_phase        (t_phase),
        .m_idx          (m_idx),
        .ir_load        (ir_load),
        .instr_done     (instr_done),
        .int_dispatch   (int_dispatch),
        .halted         (halted),
        .locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [2:0] len;
        logic [2:0] cond;
        logic       ct;
        int         cycles;
    } vec_t;

    vec_t       tbl [10];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_ir = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Runs one ordinary instruction from its t_phase 0 cycle to the next one.
    task automatic run_one(input vec_t v);
        bit done;
        int took;
        done = 0;
        took = 0;
        instr_len = v.len; cond_len = v.cond; cond_true = v.ct;
        opcode_fetched = v.op; prefix_op = 0; halt_op = 0; illegal_op = 0; int_req = 0;
        #1;
        chk("ir_at_start", ir, exp_ir);
        for (int c = 0; c < 40 && !done; c++) begin
            chk("t_phase_seq", t_phase, c % 4);
            chk("m_idx_seq", m_idx, c / 4);
            if (instr_done) begin
                done = 1;
                took = c + 1;
                chk("ir_load_with_done", ir_load, 1);
            end
            tick();
        end
        if (!done) chk("instr_done_timeout", 0, 1);
        chk("instr_cycles", took, v.cycles);
        exp_ir = v.op;
        chk("ir_after_load", ir, exp_ir);
        $display("instr op=%02h len=%0d cond=%0d ct=%0d cycles=%0d", v.op, v.len, v.cond, v.ct, took);
    endtask

    // Called in the first INT_DISPATCH cycle; checks 5 M-cycles then ISR fetch.
    task automatic dispatch_check(input logic [7:0] held, input logic [7:0] isr);
        int_req = 0;
        opcode_fetched = 8'hEE;
        for (int k = 0; k < 20; k++) begin
            if (k == 19) opcode_fetched = isr;
            #1;
            chk("disp_active", int_dispatch, 1);
            chk("disp_m_idx", m_idx, k / 4);
            chk("disp_ir_held", ir, held);
            if (k == 3 || k == 19) chk("disp_ir_load", ir_load, (k == 19) ? 1 : 0);
            tick();
        end
        chk("isr_ir", ir, isr);
        chk("isr_no_disp", int_dispatch, 0);
        chk("isr_cb", cb_prefix, 0);
        chk("isr_m_idx", m_idx, 0);
        chk("isr_t_phase", t_phase, 0);
        exp_ir = isr;
        $display("dispatch held=%02h isr=%02h", held, isr);
    endtask

    task automatic check_reset_state();
        chk("rst_ir", ir, 0);
        chk("rst_cb", cb_prefix, 0);
        chk("rst_t_phase", t_phase, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_instr_done", instr_done, 0);
        chk("rst_int_dispatch", int_dispatch, 0);
        chk("rst_halted", halted, 0);
        chk("rst_locked", locked, 0);
    endtask

    initial begin
        tbl[0] = '{op: 8'h80, len: 3'd1, cond: 3'd0, ct: 1'b0, cycles: 4};
        tbl[1] = '{op: 8'h81, len: 3'd1, cond: 3'd0, ct: 1'b0, cycles: 4};
        tbl[2] = '{op: 8'h20, len: 3'd0, cond: 3'd0, ct: 1'b1, cycles: 4};
        tbl[3] = '{op: 8'h28, len: 3'd3, cond: 3'd2, ct: 1'b0, cycles: 8};
        tbl[4] = '{op: 8'hC4, len: 3'd3, cond: 3'd2, ct: 1'b1, cycles: 12};
        tbl[5] = '{op: 8'hC0, len: 3'd6, cond: 3'd3, ct: 1'b0, cycles: 12};
        tbl[6] = '{op: 8'hC8, len: 3'd5, cond: 3'd2, ct: 1'b1, cycles: 20};
        tbl[7] = '{op: 8'hCD, len: 3'd5, cond: 3'd2, ct: 1'b0, cycles: 8};
        tbl[8] = '{op: 8'h00, len: 3'd6, cond: 3'd0, ct: 1'b0, cycles: 24};
        tbl[9] = '{op: 8'h3E, len: 3'd4, cond: 3'd0, ct: 1'b0, cycles: 16};

        reset_n = 0; opcode_fetched = 8'h80; instr_len = 3'd1; cond_len = 0; cond_true = 0;
        prefix_op = 0; halt_op = 0; illegal_op = 0; ime = 0; int_req = 0;
        #12;
        check_reset_state();
        @(negedge clk);
        reset_n = 1;

        // Instruction length table, starting with the reset NOP.
        for (int i = 0; i < 10; i++) run_one(tbl[i]);

        // CB prefix: pending interrupt is held off until the prefixed opcode completes.
        instr_len = 1; cond_len = 0; prefix_op = 1; opcode_fetched = 8'h37;
        ime = 1; int_req = 1;
        advance(3);
        #1;
        chk("cb_ir_load", ir_load, 1);
        chk("cb_no_disp", int_dispatch, 0);
        tick();
        chk("cb_ir", ir, 8'h37);
        chk("cb_flag", cb_prefix, 1);
        prefix_op = 0; opcode_fetched = 8'h99;
        advance(3);
        #1;
        chk("cb_done_then_int", instr_done, 1);
        chk("cb_int_no_load", ir_load, 0);
        tick();
        chk("cb_flag_in_disp", cb_prefix, 1);
        dispatch_check(8'h37, 8'h40);

        // Interrupt rising exactly at T3 of the final M-cycle of a 2-cycle instruction.
        instr_len = 2; ime = 1; int_req = 0; opcode_fetched = 8'h12;
        advance(3);
        #1;
        chk("m0_boundary_no_load", ir_load, 0);
        advance(4);
        int_req = 1;
        #1;
        chk("late_int_done", instr_done, 1);
        chk("late_int_no_load", ir_load, 0);
        tick();
        dispatch_check(8'h40, 8'h48);

        // HALT with ime=0 resumes without dispatch.
        run_one('{op: 8'h76, len: 3'd1, cond: 3'd0, ct: 1'b0, cycles: 4});
        halt_op = 1; ime = 0; int_req = 0; opcode_fetched = 8'h11;
        advance(3);
        #1;
        chk("halt_done", instr_done, 1);
        chk("halt_no_load", ir_load, 0);
        tick();
        chk("halted_set", halted, 1);
        advance(5);
        chk("halt_m_idx", m_idx, 0);
        chk("halt_t_phase_runs", t_phase, 1);
        chk("halt_ir_held", ir, 8'h76);
        int_req = 1;
        advance(2);
        chk("halt_exit_load", ir_load, 1);
        tick();
        chk("halt_resume", halted, 0);
        chk("halt_resume_nodisp", int_dispatch, 0);
        chk("halt_resume_ir", ir, 8'h11);
        $display("halt ime=0 resumed ir=%02h", ir);

        // HALT with ime=1 goes to dispatch.
        int_req = 0; halt_op = 1;
        advance(3);
        tick();
        chk("halted_again", halted, 1);
        ime = 1; int_req = 1; halt_op = 1;
        advance(3);
        chk("halt_int_no_load", ir_load, 0);
        tick();
        chk("halt_int_left", halted, 0);
        halt_op = 0;
        dispatch_check(8'h11, 8'h50);

        // Hard lock, then reset while locked.
        exp_ir = 8'h50;
        run_one('{op: 8'hD3, len: 3'd1, cond: 3'd0, ct: 1'b0, cycles: 4});
        illegal_op = 1; opcode_fetched = 8'h99;
        advance(3);
        chk("lock_no_done", instr_done, 0);
        chk("lock_no_load", ir_load, 0);
        tick();
        chk("locked_set", locked, 1);
        chk("lock_t_phase", t_phase, 0);
        advance(6);
        chk("lock_t_frozen", t_phase, 0);
        chk("lock_ir", ir, 8'hD3);
        chk("lock_still", locked, 1);
        $display("locked ir=%02h t_phase=%0d", ir, t_phase);
        #2;
        reset_n = 0;
        #1;
        check_reset_state();
        @(negedge clk);
        reset_n = 1; illegal_op = 0;
        exp_ir = 8'h00;
        run_one('{op: 8'h80, len: 3'd1, cond: 3'd0, ct: 1'b0, cycles: 4});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
